// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: OUT/SET/CLR/TGL, synchronised IN, optional edge interrupts.
// Optional feature macro: GPIO_IRQ_EN (IEN/PEND registers, edge detector, irq).

module gpio_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic xtal,
  input  logic resetn,
  input  logic pad,
  input  logic pend_clr,
  output logic in_sync,
  output logic pend
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge xtal or negedge resetn)
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};

  assign in_sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  logic prev_q, pend_q;

  // A fresh edge outranks a same-cycle W1C so no event is ever lost.
  always_ff @(posedge xtal or negedge resetn)
    if (!resetn) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= in_sync;
      pend_q <= (pend_q & ~pend_clr) | (in_sync & ~prev_q);
    end

  assign pend = pend_q;
`else
  logic lane_unused;
  assign lane_unused = pend_clr;
  assign pend        = 1'b0;
`endif
endmodule

module gpio_port #(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0
) (
  input  logic             xtal,
  input  logic             resetn,
  input  logic [4:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic [3:0]       bus_wmask,
  input  logic             bus_wr,
  input  logic             bus_rd,
  output logic [31:0]      bus_rdata,
  output logic             bus_ready,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio,
  output logic             irq
);
  localparam int NB = (WIDTH + 7) / 8;

  typedef enum logic [2:0] {
    R_OUT, R_SET, R_CLR, R_TGL, R_IN, R_IEN, R_PEND, R_RSV
  } reg_e;

  typedef struct packed {
    logic             wr;
    logic             rd;
    reg_e             sel;
    logic [WIDTH-1:0] data;
  } bus_req_t;

  bus_req_t         req;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] in_sync, pend, pend_clr, ien;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  // Writes only land when every byte lane covering the pins is enabled.
  assign req.wr   = bus_wr && (&bus_wmask[NB-1:0]);
  assign req.rd   = bus_rd;
  assign req.sel  = reg_e'(bus_addr[4:2]);
  assign req.data = bus_wdata[WIDTH-1:0];

  assign unused_bits = ^{bus_wdata, bus_wmask, bus_addr[1:0]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gpio_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .xtal     (xtal),
      .resetn   (resetn),
      .pad      (gpio_in[i]),
      .pend_clr (pend_clr[i]),
      .in_sync  (in_sync[i]),
      .pend     (pend[i])
    );
  end

  always_comb begin
    out_d = out_q;
    if (req.wr)
      case (req.sel)
        R_OUT:   out_d = req.data;
        R_SET:   out_d = out_q | req.data;
        R_CLR:   out_d = out_q & ~req.data;
        R_TGL:   out_d = out_q ^ req.data;
        default: out_d = out_q;
      endcase
  end

  always_ff @(posedge xtal or negedge resetn)
    if (!resetn) out_q <= RESET_OUT[WIDTH-1:0];
    else         out_q <= out_d;

  assign gpio = out_q;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] ien_q;

  always_ff @(posedge xtal or negedge resetn)
    if (!resetn)                      ien_q <= '0;
    else if (req.wr && req.sel == R_IEN) ien_q <= req.data;

  assign ien      = ien_q;
  assign pend_clr = (req.wr && req.sel == R_PEND) ? req.data : '0;
  assign irq      = |(pend & ien_q);
`else
  assign ien      = '0;
  assign pend_clr = '0;
  assign irq      = 1'b0;
`endif

  // Read mux sees pre-write flop state, so a combined rd+wr returns old data.
  always_comb begin
    rd_mux = '0;
    case (req.sel)
      R_OUT:   rd_mux[WIDTH-1:0] = out_q;
      R_IN:    rd_mux[WIDTH-1:0] = in_sync;
      R_IEN:   rd_mux[WIDTH-1:0] = ien;
      R_PEND:  rd_mux[WIDTH-1:0] = pend;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge xtal or negedge resetn)
    if (!resetn) begin
      bus_rdata <= '0;
      bus_ready <= 1'b0;
    end else begin
      bus_ready <= bus_rd | bus_wr;
      if (req.rd) bus_rdata <= rd_mux;
    end
endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port; irq/IEN/PEND expectations follow GPIO_IRQ_EN.

module tb_gpio_port;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        xtal = 1'b0;
  logic        resetn;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_wr, bus_rd;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  gpio_in, gpio;
  logic        irq;

  int tests = 0;
  int fails = 0;

  gpio_port dut (
    .xtal(xtal), .resetn(resetn), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .gpio_in(gpio_in), .gpio(gpio), .irq(irq)
  );

  always #5 xtal = ~xtal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe for one cycle; returns 1 time unit after the sampling edge.
  task automatic bus_op(input logic wr, input logic rd, input logic [4:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
    bus_wr = wr; bus_rd = rd; bus_addr = addr; bus_wdata = data; bus_wmask = mask;
    @(posedge xtal); #1;
    bus_wr = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge xtal);
    #1;
  endtask

  initial begin
    resetn = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wmask = '0;
    bus_wr = 1'b0; bus_rd = 1'b0; gpio_in = '0;
    idle(2);
    chk("rst_gpio",  32'(gpio), 32'h00);
    chk("rst_irq",   32'(irq), 32'h0);
    chk("rst_ready", 32'(bus_ready), 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    resetn = 1'b1;
    idle(1);
    chk("post_rst_ready", 32'(bus_ready), 32'h0);

    bus_op(0, 1, 5'h00, 0, 4'hF);
    chk("rd_out0_data",  bus_rdata, 32'h00);
    chk("rd_out0_ready", 32'(bus_ready), 32'h1);
    idle(1);
    chk("ready_drops", 32'(bus_ready), 32'h0);

    bus_op(1, 0, 5'h00, 32'hA5, 4'hF);
    chk("wr_out",  32'(gpio), 32'hA5);
    chk("wr_ready", 32'(bus_ready), 32'h1);
    bus_op(1, 0, 5'h04, 32'h0F, 4'hF);
    chk("set", 32'(gpio), 32'hAF);
    bus_op(1, 0, 5'h08, 32'h81, 4'hF);
    chk("clr", 32'(gpio), 32'h2E);
    bus_op(1, 0, 5'h0C, 32'hFF, 4'hF);
    chk("tgl", 32'(gpio), 32'hD1);
    bus_op(1, 0, 5'h00, 32'h3C, 4'b1110);
    chk("masked_gpio",  32'(gpio), 32'hD1);
    chk("masked_ready", 32'(bus_ready), 32'h1);
    bus_op(1, 0, 5'h08, 32'hFFFF_FF01, 4'hF);
    chk("upper_ignored", 32'(gpio), 32'hD0);
    bus_op(0, 1, 5'h00, 0, 4'hF);
    chk("rd_out", bus_rdata, 32'hD0);
    bus_op(0, 1, 5'h04, 0, 4'hF);
    chk("rd_set_zero", bus_rdata, 32'h0);
    bus_op(1, 0, 5'h1C, 32'hFF, 4'hF);
    bus_op(0, 1, 5'h1C, 0, 4'hF);
    chk("rd_rsv_zero", bus_rdata, 32'h0);
    chk("rsv_no_effect", 32'(gpio), 32'hD0);

    // back-to-back writes, then a combined read+write
    bus_op(1, 0, 5'h04, 32'h01, 4'hF);
    chk("b2b_1_gpio",  32'(gpio), 32'hD1);
    chk("b2b_1_ready", 32'(bus_ready), 32'h1);
    bus_op(1, 0, 5'h04, 32'h02, 4'hF);
    chk("b2b_2_gpio",  32'(gpio), 32'hD3);
    chk("b2b_2_ready", 32'(bus_ready), 32'h1);
    bus_op(1, 1, 5'h00, 32'h55, 4'hF);
    chk("rdwr_old_data", bus_rdata, 32'hD3);
    chk("rdwr_gpio",     32'(gpio), 32'h55);

    // input path and edge capture
    bus_op(1, 0, 5'h14, 32'h02, 4'hF);
    chk("ien_irq_quiet", 32'(irq), 32'h0);
    gpio_in = 8'h12;
    idle(1);
    bus_op(0, 1, 5'h10, 0, 4'hF);
    chk("in_not_yet", bus_rdata, 32'h00);
    bus_op(0, 1, 5'h10, 0, 4'hF);
    chk("in_sync", bus_rdata, 32'h12);
    chk("irq_set", 32'(irq), 32'(IRQ));
    bus_op(0, 1, 5'h18, 0, 4'hF);
    chk("pend_rd", bus_rdata, IRQ ? 32'h12 : 32'h0);
    bus_op(1, 0, 5'h18, 32'h02, 4'hF);
    chk("w1c_irq", 32'(irq), 32'h0);
    bus_op(0, 1, 5'h18, 0, 4'hF);
    chk("pend_after_w1c", bus_rdata, IRQ ? 32'h10 : 32'h0);

    // edge and W1C on bit 4 in the same cycle
    gpio_in = 8'h02;
    idle(4);
    bus_op(1, 0, 5'h18, 32'h10, 4'hF);
    bus_op(0, 1, 5'h18, 0, 4'hF);
    chk("pend_cleared", bus_rdata, 32'h0);
    gpio_in = 8'h12;
    idle(2);
    bus_op(1, 0, 5'h18, 32'h10, 4'hF);
    chk("collide_irq", 32'(irq), 32'h0);
    bus_op(0, 1, 5'h18, 0, 4'hF);
    chk("collide_set_wins", bus_rdata, IRQ ? 32'h10 : 32'h0);
    bus_op(1, 0, 5'h14, 32'h10, 4'hF);
    chk("ien_irq_same_cycle", 32'(irq), 32'(IRQ));
    bus_op(0, 1, 5'h14, 0, 4'hF);
    chk("ien_rd", bus_rdata, IRQ ? 32'h10 : 32'h0);

    // reset in the middle of a write
    bus_wr = 1'b1; bus_addr = 5'h04; bus_wdata = 32'hFF; bus_wmask = 4'hF;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_gpio",  32'(gpio), 32'h00);
    chk("midrst_ready", 32'(bus_ready), 32'h0);
    chk("midrst_irq",   32'(irq), 32'h0);
    chk("midrst_rdata", bus_rdata, 32'h0);
    bus_wr = 1'b0;
    idle(1);
    resetn = 1'b1;
    idle(1);
    chk("after_rst_ready", 32'(bus_ready), 32'h0);
    chk("after_rst_gpio",  32'(gpio), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_port.md
# gpio_port

Memory-mapped 8-bit GPIO peripheral inside the SoC: it drives the `gpio` output pins that the top-level bench monitors and samples external `gpio_in` pins. It sits between the CPU data-bus decoder and the pads. It provides atomic set/clear/toggle writes, a synchronised input register, and optional rising-edge interrupt capture.

## Interface
- `WIDTH`, 8: number of GPIO pins (1..32).
- `SYNC_STAGES`, 2: input synchroniser depth (≥2).
- `RESET_OUT`, 0: reset value of the OUT register.

Ports:
- `xtal`  in  1  system clock; all logic on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `bus_addr`  in  5  byte offset within the peripheral; bits [4:2] select the register.
- `bus_wdata`  in  32  write data.
- `bus_wmask`  in  4  byte enables; only bit 0 (and bits covering WIDTH) are honoured.
- `bus_wr`  in  1  write strobe, single cycle.
- `bus_rd`  in  1  read strobe, single cycle.
- `bus_rdata`  out  32  registered read data, zero-extended.
- `bus_ready`  out  1  one-cycle acknowledge for a read or write.
- `gpio_in`  in  WIDTH  asynchronous pad inputs.
- `gpio`  out  WIDTH  pin outputs, driven directly from the OUT register.
- `irq`  out  1  level interrupt: OR of (PEND & IEN).

## Operation
Register map (offsets):
- 0x00 OUT: read/write.
- 0x04 SET: write-only; OUT |= wdata.
- 0x08 CLR: write-only; OUT &= ~wdata.
- 0x0C TGL: write-only; OUT ^= wdata.
- 0x10 IN: read-only; synchronised input.
- 0x14 IEN: read/write.
- 0x18 PEND: write-1-to-clear.
- 0x1C: reserved; reads 0, writes ignored.

Write-only registers read back 0.

Writes:
- Apply only when the byte enables covering bits [WIDTH-1:0] are set.
- A masked write is acknowledged but has no effect.
- Upper `bus_wdata` bits beyond WIDTH are ignored.

Input path:
- `gpio_in` passes through a SYNC_STAGES flop chain, then one extra "previous" flop.
- A rising edge is `sync & ~prev`; it sets the matching PEND bit.

Simultaneous events:
- An edge and a W1C on the same PEND bit in the same cycle: the set wins and the bit stays 1.
- `bus_rd` and `bus_wr` asserted together is illegal upstream. The block performs the write and returns read data from the pre-write state.

Reset values:
- OUT = RESET_OUT; IEN = 0; PEND = 0.
- Sync chain and prev flops = 0.
- `bus_rdata` = 0, `bus_ready` = 0, `irq` = 0.
- Asserting reset mid-transaction drops the acknowledge; no `bus_ready` follows the deassertion of reset.

## Timing
- Write: strobe at cycle N → register updated and `gpio` changed at N+1; `bus_ready` high for exactly cycle N+1.
- Read: strobe at N → `bus_rdata` valid and `bus_ready` high at N+1. `bus_rdata` holds until the next read.
- Input latency: a pad change is visible in IN after SYNC_STAGES cycles; the PEND set occurs on the following edge.
- `irq` is combinational from the PEND/IEN flops, so it is high in the same cycle PEND or IEN goes high.
- Back-to-back strobes every cycle are supported; each receives its own `bus_ready` one cycle later.

## Configuration
`GPIO_IRQ_EN`:
- Defined: IEN, PEND, the edge detector and `irq` are implemented as described.
- Undefined:
  - IEN and PEND read 0 and writes to them are ignored (but acknowledged).
  - The prev flop and edge logic are removed.
  - `irq` is tied to 0.
  - The IN path and OUT/SET/CLR/TGL behaviour are unchanged.

## Test plan
- Reset with RESET_OUT=0x00 → `gpio`=0x00, `irq`=0, `bus_ready`=0. Read OUT → 0x00 with `bus_ready` one cycle after the strobe.
- Write OUT=0xA5, SET 0x0F, CLR 0x81, TGL 0xFF → `gpio` = 0xA5, 0xAF, 0x2E, 0xD1, each one cycle after its strobe.
- Write OUT=0x3C with `bus_wmask`=4'b1110 → acknowledged; `gpio` stays 0xD1.
- Drive `gpio_in`=0x00→0x12 with IEN=0x02 → IN reads 0x12 after 2 cycles, PEND reads 0x12 and `irq`=1. W1C 0x02 → `irq`=0; PEND reads 0x10.
- Rising edge on bit 4 in the same cycle as a W1C of 0x10 → PEND bit 4 remains 1.
- Build without `GPIO_IRQ_EN` and repeat the previous input toggles → PEND and IEN read 0 and `irq` stays 0 throughout.
